// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a bus-loaded ALU through one operation per request.
// A request is accepted in IDLE, its operands are pushed over the shared
// alu_data bus with one load strobe per state (A, B, carry-in), the result is
// sampled after one EXEC cycle, and it is held in DONE until the consumer
// takes it.
// Optional feature: define ALU_SEQ_CHAIN_EN to add req_chain, which lets a
// request reuse the previous result in place of req_a.
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_cn,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             req_chain,
`endif
  output logic [WIDTH-1:0] alu_data,
  output logic             alu_lddr1,
  output logic             alu_lddr2,
  output logic             alu_ldcn,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  input  logic [WIDTH-1:0] alu_f,
  input  logic [15:0]      alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic [15:0]      rsp_flag,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_CN,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] b_lat;
  logic             cn_lat;
  logic [2:0]       strobe;
`ifdef ALU_SEQ_CHAIN_EN
  logic [WIDTH-1:0] last_result;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign {alu_lddr1, alu_lddr2, alu_ldcn} = strobe;

  // Main sequencer: the operand for each load state is put on alu_data at the
  // edge entering that state, so it is stable for the whole state and is still
  // valid when the ALU's gated clock rises at the edge leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_data  <= '0;
      alu_s     <= '0;
      alu_m     <= 1'b0;
      b_lat     <= '0;
      cn_lat    <= 1'b0;
      rsp_f     <= '0;
      rsp_flag  <= '0;
      rsp_valid <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      last_result <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= LOAD_A;
            alu_s    <= req_s;
            alu_m    <= req_m;
            cn_lat   <= req_cn;
            b_lat    <= req_b;
`ifdef ALU_SEQ_CHAIN_EN
            alu_data <= req_chain ? last_result : req_a;
`else
            alu_data <= req_a;
`endif
          end
        end
        LOAD_A: begin
          state    <= LOAD_B;
          alu_data <= b_lat;
        end
        LOAD_B: begin
          state    <= LOAD_CN;
          alu_data <= {{(WIDTH-1){1'b0}}, cn_lat};
        end
        LOAD_CN: begin
          state <= EXEC;
        end
        EXEC: begin
          state     <= DONE;
          rsp_f     <= alu_f;
          rsp_flag  <= alu_flag;
          rsp_valid <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
          last_result <= alu_f;
`endif
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Load strobes change on the falling edge so each one straddles the rising
  // edge that ends its load state; reset clears them at the next falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      strobe <= 3'b000;
    end else begin
      case (state)
        LOAD_A:  strobe <= 3'b100;
        LOAD_B:  strobe <= 3'b010;
        LOAD_CN: strobe <= 3'b001;
        default: strobe <= 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven bench for alu_op_sequencer with a small
// bus-loaded ALU attached. Define ALU_SEQ_CHAIN_EN to exercise result chaining.
module tb_alu_op_sequencer;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_s;
  logic             req_m;
  logic             req_cn;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_chain;
  logic [WIDTH-1:0] alu_data;
  logic             alu_lddr1;
  logic             alu_lddr2;
  logic             alu_ldcn;
  logic [3:0]       alu_s;
  logic             alu_m;
  logic [WIDTH-1:0] alu_f;
  logic [15:0]      alu_flag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic [15:0]      rsp_flag;
  logic             busy;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int resp_count = 0;
  int accept_cycles[$];
  logic [WIDTH-1:0] last_f = '0;

  typedef struct {
    logic [3:0]       s;
    logic             m;
    logic             cn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             chain;
    logic [WIDTH-1:0] exp_f;
    logic [15:0]      exp_flag;
  } vec_t;

  vec_t vecs[7];

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_s(req_s),
    .req_m(req_m),
    .req_cn(req_cn),
    .req_a(req_a),
    .req_b(req_b),
`ifdef ALU_SEQ_CHAIN_EN
    .req_chain(req_chain),
`endif
    .alu_data(alu_data),
    .alu_lddr1(alu_lddr1),
    .alu_lddr2(alu_lddr2),
    .alu_ldcn(alu_ldcn),
    .alu_s(alu_s),
    .alu_m(alu_m),
    .alu_f(alu_f),
    .alu_flag(alu_flag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_f(rsp_f),
    .rsp_flag(rsp_flag),
    .busy(busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Attached ALU: operand registers clocked by (strobe AND clk).
  logic [WIDTH-1:0] dr1 = '0;
  logic [WIDTH-1:0] dr2 = '0;
  logic             cnr = 1'b0;

  always @(posedge clk) begin
    if (alu_lddr1) dr1 <= alu_data;
    if (alu_lddr2) dr2 <= alu_data;
    if (alu_ldcn)  cnr <= alu_data[0];
  end

  // ALU function: logic mode (m=1) plus add (m=0, s=1001); flags are
  // {msb, 13'b0, carry, zero}.
  always_comb begin
    logic [WIDTH:0] sum;
    logic           carry;
    logic [WIDTH-1:0] f;
    sum   = {1'b0, dr1} + {1'b0, dr2} + {{WIDTH{1'b0}}, cnr};
    carry = 1'b0;
    f     = dr1;
    if (alu_m) begin
      case (alu_s)
        4'b0000: f = ~dr1;
        4'b0001: f = ~(dr1 | dr2);
        4'b0010: f = ~dr1 & dr2;
        4'b0011: f = '0;
        4'b0100: f = ~(dr1 & dr2);
        4'b0101: f = ~dr2;
        4'b0110: f = dr1 ^ dr2;
        4'b0111: f = dr1 & ~dr2;
        4'b1000: f = ~dr1 | dr2;
        4'b1001: f = ~(dr1 ^ dr2);
        4'b1010: f = dr2;
        4'b1011: f = dr1 & dr2;
        4'b1100: f = '1;
        4'b1101: f = dr1 | ~dr2;
        4'b1110: f = dr1 | dr2;
        default: f = dr1;
      endcase
    end else if (alu_s == 4'b1001) begin
      f     = sum[WIDTH-1:0];
      carry = sum[WIDTH];
    end
    alu_f    = f;
    alu_flag = {f[WIDTH-1], 13'b0, carry, (f == '0)};
  end

  // Log accept edges and delivered responses.
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) accept_cycles.push_back(cycle);
    if (!rst && rsp_valid && rsp_ready) resp_count++;
    cycle++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobes may only move on falling edges and never overlap.
  always @(alu_lddr1 or alu_lddr2 or alu_ldcn) begin
    check_output("strobe_on_negedge", {31'b0, clk}, 32'd0);
    check_output("strobe_onehot", {31'b0, $onehot0({alu_lddr1, alu_lddr2, alu_ldcn})}, 32'd1);
  end

  // One full operation, starting just after a rising edge with the DUT idle.
  // stall > 0 holds rsp_ready low in DONE for that many cycles while poking
  // req_valid, which must be ignored.
  task automatic apply_stimulus(input vec_t v, input int stall);
    logic [WIDTH-1:0] exp_a;
    logic [2:0] exp_strobe;
    logic [WIDTH-1:0] exp_data;
    int acc_before;
    exp_a = v.chain ? last_f : v.a;
    check_output("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_s = v.s; req_m = v.m; req_cn = v.cn; req_a = v.a; req_b = v.b; req_chain = v.chain;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_before = accept_cycles.size();
    check_output("alu_s_latched", {28'b0, alu_s}, {28'b0, v.s});
    check_output("alu_m_latched", {31'b0, alu_m}, {31'b0, v.m});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      exp_strobe = (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : (k == 2) ? 3'b001 : 3'b000;
      check_output("strobes", {29'b0, alu_lddr1, alu_lddr2, alu_ldcn}, {29'b0, exp_strobe});
      if (k < 3) begin
        exp_data = (k == 0) ? exp_a : (k == 1) ? v.b : {{(WIDTH-1){1'b0}}, v.cn};
        check_output("alu_data", {16'b0, alu_data}, {16'b0, exp_data});
      end
      @(posedge clk); #1;
      check_output("rsp_valid_latency", {31'b0, rsp_valid}, {31'b0, (k == 3)});
    end
    check_output("rsp_f", {16'b0, rsp_f}, {16'b0, v.exp_f});
    check_output("rsp_flag", {16'b0, rsp_flag}, {16'b0, v.exp_flag});
    for (int i = 0; i < stall; i++) begin
      req_a = 16'hDEAD;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_output("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check_output("stall_rsp_f", {16'b0, rsp_f}, {16'b0, v.exp_f});
      check_output("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    if (stall > 0) begin
      check_output("stall_no_accept", accept_cycles.size(), acc_before);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_output("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
    check_output("back_to_idle", {31'b0, req_ready}, 32'd1);
    last_f = v.exp_f;
  endtask

  initial begin
    int resp_before;
    vec_t cv;
    vecs[0] = '{4'b0110, 1'b1, 1'b0, 16'h00FF, 16'h0F0F, 1'b0, 16'h0FF0, 16'h0000};
    vecs[1] = '{4'b1011, 1'b1, 1'b0, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 16'h8000};
    vecs[2] = '{4'b1110, 1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0, 16'h5335, 16'h0000};
    vecs[3] = '{4'b1001, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0004, 16'h0000};
    vecs[4] = '{4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0003};
    vecs[5] = '{4'b0011, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 16'h0000, 16'h0001};
    vecs[6] = '{4'b0000, 1'b1, 1'b0, 16'h00FF, 16'h1111, 1'b0, 16'hFF00, 16'h8000};

    rst = 1'b1; req_valid = 1'b0; req_s = '0; req_m = 1'b0; req_cn = 1'b0;
    req_a = '0; req_b = '0; req_chain = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_output("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("rst_alu_data", {16'b0, alu_data}, 32'd0);
    check_output("rst_rsp_f", {16'b0, rsp_f}, 32'd0);
    check_output("rst_strobes", {29'b0, alu_lddr1, alu_lddr2, alu_ldcn}, 32'd0);
    rst = 1'b0;

    // Table vectors back to back with rsp_ready high.
    accept_cycles.delete();
    resp_count = 0;
    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], 0);
    check_output("accept_count", accept_cycles.size(), 32'd7);
    check_output("resp_count", resp_count, 32'd7);
    for (int i = 1; i < accept_cycles.size(); i++)
      check_output("accept_spacing", accept_cycles[i] - accept_cycles[i-1], 32'd6);

    // Consumer stalls for 5 cycles in DONE.
    apply_stimulus(vecs[0], 5);

    // Reset during LOAD_B abandons the operation.
    resp_before = resp_count;
    req_s = vecs[1].s; req_m = vecs[1].m; req_a = vecs[1].a; req_b = vecs[1].b;
    req_cn = 1'b0; req_chain = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_output("abort_in_load_b", {29'b0, alu_lddr1, alu_lddr2, alu_ldcn}, 32'b100);
    rst = 1'b1;
    @(negedge clk); #1;
    check_output("abort_strobes", {29'b0, alu_lddr1, alu_lddr2, alu_ldcn}, 32'd0);
    @(posedge clk); #1;
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check_output("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("abort_rsp_f", {16'b0, rsp_f}, 32'd0);
    check_output("abort_alu_data", {16'b0, alu_data}, 32'd0);
    check_output("abort_alu_s", {28'b0, alu_s}, 32'd0);
    rst = 1'b0;
    last_f = '0;
    repeat (8) begin
      @(posedge clk); #1;
      check_output("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    check_output("abort_resp_count", resp_count, resp_before);

`ifdef ALU_SEQ_CHAIN_EN
    // Chained op right after reset sees a cleared previous result.
    cv = '{4'b0110, 1'b1, 1'b0, 16'hABCD, 16'h0F0F, 1'b1, 16'h0F0F, 16'h0000};
    apply_stimulus(cv, 0);
    apply_stimulus(vecs[0], 0);
    cv = '{4'b0110, 1'b1, 1'b0, 16'h1234, 16'h0FF0, 1'b1, 16'h0000, 16'h0001};
    apply_stimulus(cv, 0);
`else
    cv = vecs[2];
    apply_stimulus(cv, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
